// File: rtl/spi_loader_pkg.sv
// rtl/spi_loader_pkg.sv - shared constants and FSM encoding for the SPI framebuffer loader
`timescale 1ns/1ps
package spi_loader_pkg;

  localparam int ADDR_BITS    = 12;
  localparam int FB_LAST_ADDR = 4095;

  localparam logic [7:0] CMD_NOP   = 8'h00;
  localparam logic [7:0] CMD_WRITE = 8'h01;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR_HI,
    ST_ADDR_LO,
    ST_DATA_HI,
    ST_DATA_LO,
    ST_DISCARD
  } state_t;

endpackage

// File: rtl/spi_framebuf_loader_byte_rx.sv
// rtl/spi_framebuf_loader_byte_rx.sv - SPI mode 0 byte receiver with pin synchronisers
`timescale 1ns/1ps
module spi_byte_rx (
  input  logic       clk,
  input  logic       rst,
  input  logic       spi_sck,
  input  logic       spi_cs_n,
  input  logic       spi_mosi,
  output logic       byte_valid,
  output logic [7:0] rx_byte,
  output logic       cs_fall,
  output logic       cs_rise
);

  // [0],[1] form the synchroniser, [2] is the history flop for edge detect
  logic [2:0] sck_sync;
  logic [2:0] cs_sync;
  logic [1:0] mosi_sync;
  logic [2:0] bit_cnt;
  logic [6:0] shreg;
  logic       sck_rise;
  logic       cs_active;

  assign sck_rise  = sck_sync[1] & ~sck_sync[2];
  assign cs_fall   = cs_sync[2] & ~cs_sync[1];
  assign cs_rise   = ~cs_sync[2] & cs_sync[1];
  assign cs_active = ~cs_sync[1];

  // Bring the asynchronous pins into the clk domain; cs_n idles high
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sck_sync  <= 3'b000;
      cs_sync   <= 3'b111;
      mosi_sync <= 2'b00;
    end else begin
      sck_sync  <= {sck_sync[1:0], spi_sck};
      cs_sync   <= {cs_sync[1:0], spi_cs_n};
      mosi_sync <= {mosi_sync[0], spi_mosi};
    end
  end

  // Shift MSB-first on sck rising edges while selected; pulse byte_valid on the 8th bit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt    <= 3'd0;
      shreg      <= 7'd0;
      byte_valid <= 1'b0;
      rx_byte    <= 8'd0;
    end else begin
      byte_valid <= 1'b0;
      if (cs_fall) begin
        bit_cnt <= 3'd0;
      end else if (sck_rise && cs_active) begin
        shreg   <= {shreg[5:0], mosi_sync[1]};
        bit_cnt <= bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) begin
          byte_valid <= 1'b1;
          rx_byte    <= {shreg, mosi_sync[1]};
        end
      end
    end
  end

endmodule

// File: rtl/spi_framebuf_loader.sv
// rtl/spi_framebuf_loader.sv - SPI slave that streams pixels into the framebuffer write port
`timescale 1ns/1ps
module spi_framebuf_loader #(
  parameter int COLOR_BITS  = 4,
  parameter int COLOR_COUNT = 3,
  parameter int ADDR_BITS   = spi_loader_pkg::ADDR_BITS,
  localparam int PIXEL_BITS = COLOR_BITS * COLOR_COUNT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  spi_sck,
  input  logic                  spi_cs_n,
  input  logic                  spi_mosi,
  output logic [ADDR_BITS-1:0]  write_addr,
  output logic                  w_en,
  output logic [PIXEL_BITS-1:0] pixel_out,
  output logic                  frame_done,
  output logic                  busy
);

  import spi_loader_pkg::*;

  state_t               state;
  state_t               state_nxt;
  logic                 byte_valid;
  logic [7:0]           rx_byte;
  logic                 cs_fall;
  logic                 cs_rise;
  logic [7:0]           addr_hi;
  logic [7:0]           data_hi;
  logic [ADDR_BITS-1:0] addr;

  spi_byte_rx u_byte_rx (
    .clk        (clk),
    .rst        (rst),
    .spi_sck    (spi_sck),
    .spi_cs_n   (spi_cs_n),
    .spi_mosi   (spi_mosi),
    .byte_valid (byte_valid),
    .rx_byte    (rx_byte),
    .cs_fall    (cs_fall),
    .cs_rise    (cs_rise)
  );

  assign busy = (state != ST_IDLE);

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next state: a cs_n fall always restarts at CMD, a cs_n rise always aborts
  always_comb begin
    state_nxt = state;
    if (cs_fall) begin
      state_nxt = ST_CMD;
    end else if (cs_rise) begin
      state_nxt = ST_IDLE;
    end else if (byte_valid) begin
      case (state)
        ST_CMD:     state_nxt = (rx_byte == CMD_WRITE) ? ST_ADDR_HI : ST_DISCARD;
        ST_ADDR_HI: state_nxt = ST_ADDR_LO;
        ST_ADDR_LO: state_nxt = ST_DATA_HI;
        ST_DATA_HI: state_nxt = ST_DATA_LO;
        ST_DATA_LO: state_nxt = ST_DATA_HI;
        default:    state_nxt = state;
      endcase
    end
  end

  // Address/data capture and the registered write strobe; the strobe fires the
  // cycle after the low pixel byte lands, even if cs_n rises in that same cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_hi    <= 8'd0;
      data_hi    <= 8'd0;
      addr       <= '0;
      write_addr <= '0;
      pixel_out  <= '0;
      w_en       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      w_en       <= 1'b0;
      frame_done <= 1'b0;
      if (byte_valid) begin
        case (state)
          ST_ADDR_HI: addr_hi <= rx_byte;
          ST_ADDR_LO: addr    <= ADDR_BITS'({addr_hi, rx_byte});
          ST_DATA_HI: data_hi <= rx_byte;
          ST_DATA_LO: begin
            w_en       <= 1'b1;
            write_addr <= addr;
            pixel_out  <= PIXEL_BITS'({data_hi, rx_byte});
            frame_done <= (addr == ADDR_BITS'(FB_LAST_ADDR));
            addr       <= addr + ADDR_BITS'(1);
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_framebuf_loader.sv
// tb/tb_spi_framebuf_loader.sv - self-checking bench for spi_framebuf_loader
`timescale 1ns/1ps
module tb_spi_framebuf_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        spi_sck;
  logic        spi_cs_n;
  logic        spi_mosi;
  logic [11:0] write_addr;
  logic        w_en;
  logic [11:0] pixel_out;
  logic        frame_done;
  logic        busy;

  spi_framebuf_loader dut (
    .clk        (clk),
    .rst        (rst),
    .spi_sck    (spi_sck),
    .spi_cs_n   (spi_cs_n),
    .spi_mosi   (spi_mosi),
    .write_addr (write_addr),
    .w_en       (w_en),
    .pixel_out  (pixel_out),
    .frame_done (frame_done),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef logic [7:0] bytes_t[$];
  typedef struct {
    int addr;
    int data;
    int fd;
    int cyc;
  } wr_t;

  wr_t obs_q[$];
  wr_t exp_q[$];
  int  n_checks = 0;
  int  n_pass = 0;
  int  cyc = 0;
  int  stray_fd = 0;
  int  half = 2;
  int  last_rise_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Capture every write strobe, away from the active edge
  always @(negedge clk) begin
    if (w_en)
      obs_q.push_back('{int'(write_addr), int'(pixel_out), (frame_done ? 1 : 0), cyc});
    else if (frame_done)
      stray_fd++;
  end

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic spi_bits(input logic [7:0] b, input int nbits);
    for (int i = 7; i > 7 - nbits; i--) begin
      spi_mosi = b[i];
      repeat (half) @(negedge clk);
      spi_sck = 1'b1;
      last_rise_cyc = cyc;
      repeat (half) @(negedge clk);
      spi_sck = 1'b0;
    end
  endtask

  task automatic cs_begin();
    spi_cs_n = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic cs_end();
    repeat (half) @(negedge clk);
    spi_cs_n = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  // Reference: WRITE command, 12-bit start address, one write per complete byte pair
  task automatic model_txn(input bytes_t bq);
    int a;
    int d;
    if (bq.size() >= 3 && bq[0] == 8'h01) begin
      a = {bq[1], bq[2]} % 4096;
      for (int i = 0; 4 + 2 * i < bq.size(); i++) begin
        d = {bq[3 + 2 * i], bq[4 + 2 * i]} & 'hFFF;
        exp_q.push_back('{a, d, ((a == 4095) ? 1 : 0), 0});
        a = (a + 1) % 4096;
      end
    end
  endtask

  task automatic send_txn(input bytes_t bq, input int extra_bits, input logic [7:0] extra);
    cs_begin();
    foreach (bq[i]) spi_bits(bq[i], 8);
    if (extra_bits > 0) spi_bits(extra, extra_bits);
    cs_end();
    model_txn(bq);
  endtask

  task automatic compare_writes(input string tag);
    int n;
    check({tag, ".count"}, obs_q.size(), exp_q.size());
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s.addr[%0d]", tag, i), obs_q[i].addr, exp_q[i].addr);
      check($sformatf("%s.data[%0d]", tag, i), obs_q[i].data, exp_q[i].data);
      check($sformatf("%s.fd[%0d]", tag, i), obs_q[i].fd, exp_q[i].fd);
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bytes_t q;
    int     lat_ref;
    int     n;
    int     start;

    rst = 1'b1;
    spi_sck = 1'b0;
    spi_cs_n = 1'b1;
    spi_mosi = 1'b0;
    repeat (3) @(negedge clk);
    check("reset.w_en", w_en, 0);
    check("reset.busy", busy, 0);
    check("reset.addr", write_addr, 0);
    check("reset.pixel", pixel_out, 0);
    check("reset.frame_done", frame_done, 0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // Two pixels from 0x010, with write latency and busy release timing
    cs_begin();
    check("t1.busy_high", busy, 1);
    spi_bits(8'h01, 8); spi_bits(8'h00, 8); spi_bits(8'h10, 8);
    spi_bits(8'h0A, 8); spi_bits(8'hBC, 8);
    lat_ref = last_rise_cyc;
    spi_bits(8'h01, 8); spi_bits(8'h23, 8);
    repeat (half) @(negedge clk);
    spi_cs_n = 1'b1;
    n = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      n = k;
      if (!busy) break;
    end
    check("t1.busy_fall_cycles", n, 3);
    repeat (8) @(negedge clk);
    q = '{8'h01, 8'h00, 8'h10, 8'h0A, 8'hBC, 8'h01, 8'h23};
    model_txn(q);
    if (obs_q.size() > 0) check("t1.latency", obs_q[0].cyc - lat_ref, 4);
    else check("t1.latency", -1, 4);
    compare_writes("t1");

    // Wrap from 4095 to 0 with frame_done on the last address
    q = '{8'h01, 8'h0F, 8'hFF, 8'h0F, 8'hFF, 8'h00, 8'h01};
    send_txn(q, 0, 8'h00);
    compare_writes("t2");

    // Unknown command: everything discarded
    q = '{8'h55};
    for (int i = 0; i < 6; i++) q.push_back(8'($urandom));
    send_txn(q, 0, 8'h00);
    compare_writes("t3");
    check("t3.idle", busy, 0);

    // Partial pixel dropped, then a clean transaction at its own address
    q = '{8'h01, 8'h08, 8'h00, 8'hF0, 8'hF0, 8'hAB};
    send_txn(q, 3, 8'hE0);
    q = '{8'h01, 8'h01, 8'h23, 8'h04, 8'h56};
    send_txn(q, 0, 8'h00);
    compare_writes("t4");

    // Reset in the middle of a pixel
    cs_begin();
    spi_bits(8'h01, 8); spi_bits(8'h00, 8); spi_bits(8'h20, 8);
    spi_bits(8'hAA, 5);
    #2;
    rst = 1'b1;
    spi_cs_n = 1'b1;
    spi_sck = 1'b0;
    #1;
    check("t5.rst.w_en", w_en, 0);
    check("t5.rst.addr", write_addr, 0);
    check("t5.rst.pixel", pixel_out, 0);
    check("t5.rst.busy", busy, 0);
    check("t5.rst.frame_done", frame_done, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    q = '{8'h01, 8'h00, 8'h05, 8'h07, 8'h77};
    send_txn(q, 0, 8'h00);
    compare_writes("t5");

    // Random streams at clk/4 and clk/8
    half = 2;
    start = $urandom_range(0, 4095);
    q = '{8'h01, 8'({4'($urandom), 4'(start >> 8)}), 8'(start)};
    for (int i = 0; i < 512; i++) q.push_back(8'($urandom));
    send_txn(q, 0, 8'h00);
    compare_writes("rnd4");

    half = 4;
    start = $urandom_range(3968, 4095);
    q = '{8'h01, 8'({4'($urandom), 4'(start >> 8)}), 8'(start)};
    for (int i = 0; i < 256; i++) q.push_back(8'($urandom));
    send_txn(q, 0, 8'h00);
    compare_writes("rnd8");

    check("stray_frame_done", stray_fd, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
